// File: rtl/dbg_mmreg_mc_if.sv
// dbg_mmreg_mc_if
//   Register-bus bundle between the subsystem CPU side (master) and the
//   debug register block (slave). Single-cycle strobe with a registered
//   read return one cycle later; ready is always asserted.
// Signals:
//   reg_en_i    access strobe
//   reg_addr_i  byte address, word offset taken from [7:2]
//   reg_wdata_i write data
//   reg_we_i    1 = write, 0 = read
//   reg_rdata_o registered read data
//   reg_ready_o always 1
interface dbg_mmreg_mc_if;
  logic        reg_en_i;
  logic [31:0] reg_addr_i;
  logic [31:0] reg_wdata_i;
  logic        reg_we_i;
  logic [31:0] reg_rdata_o;
  logic        reg_ready_o;

  modport master (
    output reg_en_i, reg_addr_i, reg_wdata_i, reg_we_i,
    input  reg_rdata_o, reg_ready_o
  );

  modport slave (
    input  reg_en_i, reg_addr_i, reg_wdata_i, reg_we_i,
    output reg_rdata_o, reg_ready_o
  );
endinterface

// File: rtl/dbg_mmreg_mc.sv
// dbg_mmreg_mc
//   Memory-mapped register block: TBRE start/end/go/epoch control and
//   status, NUM_CH debug FIFOs with programmable watermark and sticky
//   overflow, and one maskable interrupt with write-1-to-clear status.
// Ports:
//   clk_i            clock
//   rst_i            synchronous active-high reset
//   bus              register bus (slave side of dbg_mmreg_mc_if)
//   mmreg_coreout_i  bit0 = TBRE busy, other bits unused
//   mmreg_corein_o   {63'h0, tbre_go, tbre_end, tbre_start}
//   irq_o            |(INTR_STAT & INTR_EN)
module dbg_mmreg_mc #(
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int DW         = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  dbg_mmreg_mc_if.slave bus,
  input  logic [63:0]   mmreg_coreout_i,
  output logic [127:0]  mmreg_corein_o,
  output logic          irq_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  // Implemented INTR_EN bits: done, per-channel watermark, per-channel overflow.
  localparam logic [31:0] CH_BITS = (32'h1 << NUM_CH) - 32'h1;
  localparam logic [31:0] EN_MASK = 32'h1 | (CH_BITS << 8) | (CH_BITS << 16);

  logic       wr_op, rd_op;
  logic [5:0] off;
  logic [31:0] wdata;

  assign wr_op = bus.reg_en_i & bus.reg_we_i;
  assign rd_op = bus.reg_en_i & ~bus.reg_we_i;
  assign off   = bus.reg_addr_i[7:2];
  assign wdata = bus.reg_wdata_i;
  assign bus.reg_ready_o = 1'b1;

  logic unused_bits;
  assign unused_bits = ^{bus.reg_addr_i[31:8], bus.reg_addr_i[1:0], mmreg_coreout_i[63:1]};

  // TBRE control/status
  logic [31:0] start_reg, end_reg, en_reg, rdata_reg, rdata_next, intr_stat;
  logic [30:0] epoch_reg;
  logic        go_reg, busy_reg, done_reg, done;

  assign done = busy_reg & ~mmreg_coreout_i[0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      start_reg <= '0;
      end_reg   <= '0;
      en_reg    <= '0;
      epoch_reg <= '0;
      go_reg    <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      rdata_reg <= '0;
    end else begin
      go_reg   <= wr_op && off == 6'h02;
      busy_reg <= mmreg_coreout_i[0];
      if (wr_op && off == 6'h00) start_reg <= wdata;
      if (wr_op && off == 6'h01) end_reg   <= wdata;
      if (wr_op && off == 6'h05) en_reg    <= wdata & EN_MASK;
      if (done) epoch_reg <= epoch_reg + 31'd1;
      // A completing TBRE run outranks a simultaneous clear.
      if (done) done_reg <= 1'b1;
      else if (wr_op && off == 6'h04 && wdata[0]) done_reg <= 1'b0;
      if (rd_op) rdata_reg <= rdata_next;
    end
  end

  // Per-channel FIFO state exported to the read mux and interrupt logic
  logic [NUM_CH-1:0][7:0]  depth_w;
  logic [NUM_CH-1:0][7:0]  thr_w;
  logic [NUM_CH-1:0][15:0] head_w;
  logic [NUM_CH-1:0]       empty_w, full_w, ovf_w, wm_w;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [AW:0]    wr_reg, rd_reg, cnt;
      logic [DW-1:0]  mem_reg [FIFO_DEPTH];
      logic [7:0]     thr_reg;
      logic           ovf_reg, push, pop, stat_wr, ovf_clr, full, empty;

      // Extra pointer bit distinguishes full from empty; wrap is modulo.
      assign cnt     = wr_reg - rd_reg;
      assign full    = cnt == (AW+1)'(FIFO_DEPTH);
      assign empty   = cnt == '0;
      assign push    = wr_op && off == 6'(16 + 2*gi);
      assign pop     = rd_op && off == 6'(16 + 2*gi) && !empty;
      assign stat_wr = wr_op && off == 6'(17 + 2*gi);
      assign ovf_clr = (wr_op && off == 6'h04 && wdata[16+gi]) || (stat_wr && wdata[10]);

      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          wr_reg  <= '0;
          rd_reg  <= '0;
          ovf_reg <= 1'b0;
          thr_reg <= 8'(FIFO_DEPTH / 2);
          for (int i = 0; i < FIFO_DEPTH; i++) mem_reg[i] <= '0;
        end else begin
          if (push && !full) begin
            mem_reg[wr_reg[AW-1:0]] <= wdata[DW-1:0];
            wr_reg <= wr_reg + 1'b1;
          end
          if (pop) rd_reg <= rd_reg + 1'b1;
          // Dropped push sets overflow even if software clears it this cycle.
          if (push && full) ovf_reg <= 1'b1;
          else if (ovf_clr) ovf_reg <= 1'b0;
          if (stat_wr) thr_reg <= wdata[23:16];
        end
      end

      assign depth_w[gi] = 8'(cnt);
      assign thr_w[gi]   = thr_reg;
      assign head_w[gi]  = 16'(mem_reg[rd_reg[AW-1:0]]);
      assign empty_w[gi] = empty;
      assign full_w[gi]  = full;
      assign ovf_w[gi]   = ovf_reg;
      // Zero threshold disables; thresholds above the depth never match.
      assign wm_w[gi]    = (thr_reg != 8'd0) && (8'(cnt) >= thr_reg);
    end
  endgenerate

  always_comb begin
    intr_stat = '0;
    intr_stat[0] = done_reg;
    intr_stat[8 +: NUM_CH]  = wm_w;
    intr_stat[16 +: NUM_CH] = ovf_w;
  end

  always_comb begin
    rdata_next = '0;
    case (off)
      6'h00: rdata_next = start_reg;
      6'h01: rdata_next = end_reg;
      6'h02: rdata_next = 32'h5500_0000;
      6'h03: rdata_next = {epoch_reg, busy_reg};
      6'h04: rdata_next = intr_stat;
      6'h05: rdata_next = en_reg;
      default: rdata_next = '0;
    endcase
    for (int c = 0; c < NUM_CH; c++) begin
      if (off == 6'(16 + 2*c))
        rdata_next = {15'h0, empty_w[c], head_w[c]};
      if (off == 6'(17 + 2*c))
        rdata_next = {8'h0, thr_w[c], 5'h0, ovf_w[c], full_w[c], empty_w[c], depth_w[c]};
    end
  end

  assign bus.reg_rdata_o = rdata_reg;
  assign mmreg_corein_o  = {63'h0, go_reg, end_reg, start_reg};
  assign irq_o           = |(intr_stat & en_reg);
endmodule

// File: tb/tb_dbg_mmreg_mc.sv
// Bench for dbg_mmreg_mc (NUM_CH=4, FIFO_DEPTH=16, DW=8): a vector table for
// reset state and simple register access, then hand-written sequences for
// TBRE go/done, FIFO full/overflow/drain, watermark interrupt, pointer
// wrap and mid-burst reset.
module tb_dbg_mmreg_mc;
  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [63:0]  mmreg_coreout_i = '0;
  logic [127:0] mmreg_corein_o;
  logic         irq_o;
  int nvec  = 0;
  int nfail = 0;

  dbg_mmreg_mc_if bus();

  dbg_mmreg_mc #(.NUM_CH(4), .FIFO_DEPTH(16), .DW(8)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus(bus),
    .mmreg_coreout_i(mmreg_coreout_i),
    .mmreg_corein_o(mmreg_corein_o),
    .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        we;
    logic [5:0]  off;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic wr(input logic [5:0] off, input logic [31:0] d);
    bus.reg_en_i    = 1'b1;
    bus.reg_we_i    = 1'b1;
    bus.reg_addr_i  = {24'h0, off, 2'b00};
    bus.reg_wdata_i = d;
    @(posedge clk_i); #1;
    bus.reg_en_i = 1'b0;
    bus.reg_we_i = 1'b0;
  endtask

  task automatic rd(input logic [5:0] off, output logic [31:0] d);
    bus.reg_en_i   = 1'b1;
    bus.reg_we_i   = 1'b0;
    bus.reg_addr_i = {24'h0, off, 2'b00};
    @(posedge clk_i); #1;
    bus.reg_en_i = 1'b0;
    d = bus.reg_rdata_o;
  endtask

  task automatic rd_chk(input string name, input logic [5:0] off, input logic [31:0] exp);
    logic [31:0] d;
    rd(off, d);
    check(name, {32'h0, d}, {32'h0, exp});
  endtask

  task automatic tick;
    @(posedge clk_i); #1;
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  q[$];
    logic [7:0]  exp_b;

    bus.reg_en_i    = 1'b0;
    bus.reg_we_i    = 1'b0;
    bus.reg_addr_i  = '0;
    bus.reg_wdata_i = '0;

    // Reset state and basic register access
    vecs.push_back('{1'b0, 6'h00, 32'h0, 32'h0000_0000, "rst_start"});
    vecs.push_back('{1'b0, 6'h01, 32'h0, 32'h0000_0000, "rst_end"});
    vecs.push_back('{1'b0, 6'h02, 32'h0, 32'h5500_0000, "rst_go"});
    vecs.push_back('{1'b0, 6'h03, 32'h0, 32'h0000_0000, "rst_tbre_stat"});
    vecs.push_back('{1'b0, 6'h04, 32'h0, 32'h0000_0000, "rst_intr_stat"});
    vecs.push_back('{1'b0, 6'h05, 32'h0, 32'h0000_0000, "rst_intr_en"});
    vecs.push_back('{1'b0, 6'h10, 32'h0, 32'h0001_0000, "rst_ch0_data"});
    vecs.push_back('{1'b0, 6'h11, 32'h0, 32'h0008_0100, "rst_ch0_stat"});
    vecs.push_back('{1'b0, 6'h13, 32'h0, 32'h0008_0100, "rst_ch1_stat"});
    vecs.push_back('{1'b0, 6'h15, 32'h0, 32'h0008_0100, "rst_ch2_stat"});
    vecs.push_back('{1'b0, 6'h17, 32'h0, 32'h0008_0100, "rst_ch3_stat"});
    vecs.push_back('{1'b0, 6'h18, 32'h0, 32'h0000_0000, "unmapped_ch4"});
    vecs.push_back('{1'b1, 6'h06, 32'hDEAD_BEEF, 32'h0, "wr_unmapped"});
    vecs.push_back('{1'b0, 6'h06, 32'h0, 32'h0000_0000, "rd_unmapped"});
    vecs.push_back('{1'b1, 6'h05, 32'hFFFF_FFFF, 32'h0, "wr_en_all"});
    vecs.push_back('{1'b0, 6'h05, 32'h0, 32'h000F_0F01, "rd_en_mask"});
    vecs.push_back('{1'b1, 6'h05, 32'h0, 32'h0, "wr_en_zero"});
    vecs.push_back('{1'b1, 6'h00, 32'h2000_0000, 32'h0, "wr_start"});
    vecs.push_back('{1'b1, 6'h01, 32'h2000_1000, 32'h0, "wr_end"});
    vecs.push_back('{1'b0, 6'h00, 32'h0, 32'h2000_0000, "rd_start"});
    vecs.push_back('{1'b0, 6'h01, 32'h0, 32'h2000_1000, "rd_end"});

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_irq", {63'h0, irq_o}, 64'h0);
    check("rst_corein_hi", mmreg_corein_o[127:64], 64'h0);
    rst_i = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].we) wr(vecs[i].off, vecs[i].wdata);
      else rd_chk(vecs[i].name, vecs[i].off, vecs[i].exp);
    end

    // GO pulse: exactly one cycle, the cycle after the write
    check("corein_addrs", mmreg_corein_o[63:0], 64'h2000_1000_2000_0000);
    check("go_before", {63'h0, mmreg_corein_o[64]}, 64'h0);
    wr(6'h02, 32'h1);
    check("go_pulse", {63'h0, mmreg_corein_o[64]}, 64'h1);
    tick();
    check("go_after", {63'h0, mmreg_corein_o[64]}, 64'h0);

    // Three busy falling edges with done interrupt enabled
    wr(6'h05, 32'h1);
    for (int i = 0; i < 3; i++) begin
      mmreg_coreout_i[0] = 1'b1;
      tick();
      mmreg_coreout_i[0] = 1'b0;
      tick();
    end
    rd_chk("epoch3", 6'h03, 32'h0000_0006);
    check("irq_done", {63'h0, irq_o}, 64'h1);
    wr(6'h04, 32'h1);
    check("irq_cleared", {63'h0, irq_o}, 64'h0);
    rd_chk("done_cleared", 6'h04, 32'h0);

    // Done edge coincident with W1C: set wins
    mmreg_coreout_i[0] = 1'b1;
    tick();
    mmreg_coreout_i[0] = 1'b0;
    wr(6'h04, 32'h1);
    rd_chk("done_set_wins", 6'h04, 32'h1);
    rd_chk("epoch4", 6'h03, 32'h0000_0008);
    wr(6'h04, 32'h1);
    wr(6'h05, 32'h0);

    // Ch2: fill, overflow, drain in order, pop on empty
    for (int i = 0; i < 16; i++) wr(6'h14, 32'(i));
    rd_chk("ch2_full", 6'h15, 32'h0008_0210);
    wr(6'h14, 32'hAA);
    rd_chk("ch2_ovf", 6'h15, 32'h0008_0610);
    rd_chk("intr_ch2", 6'h04, 32'h0004_0400);
    for (int i = 0; i < 16; i++) rd_chk($sformatf("ch2_pop%0d", i), 6'h14, 32'(i));
    rd_chk("ch2_pop_empty", 6'h14, 32'h0001_0000);
    rd_chk("ch2_drained", 6'h15, 32'h0008_0500);
    wr(6'h15, 32'h0008_0400);
    rd_chk("ch2_ovf_clr", 6'h15, 32'h0008_0100);

    // Ch0 watermark at 4
    wr(6'h11, 32'h0004_0000);
    wr(6'h05, 32'h0000_0100);
    wr(6'h10, 32'h11);
    wr(6'h10, 32'h22);
    wr(6'h10, 32'h33);
    check("wm_below", {63'h0, irq_o}, 64'h0);
    wr(6'h10, 32'h44);
    check("wm_reached", {63'h0, irq_o}, 64'h1);
    rd_chk("wm_pop", 6'h10, 32'h0000_0011);
    check("wm_dropped", {63'h0, irq_o}, 64'h0);

    // Ch1 pointer wrap with a queue scoreboard, kept 5 deep
    for (int i = 0; i < 5; i++) begin
      exp_b = 8'(i + 200);
      wr(6'h12, {24'h0, exp_b});
      q.push_back(exp_b);
    end
    for (int i = 0; i < 40; i++) begin
      exp_b = 8'(i * 7 + 3);
      wr(6'h12, {24'h0, exp_b});
      q.push_back(exp_b);
      rd(6'h12, d);
      check($sformatf("wrap%0d", i), {32'h0, d}, {56'h0, q.pop_front()});
    end
    while (q.size() > 0) begin
      rd(6'h12, d);
      check("wrap_drain", {32'h0, d}, {56'h0, q.pop_front()});
    end
    rd_chk("wrap_depth0", 6'h13, 32'h0008_0100);

    // Reset mid-burst
    for (int i = 0; i < 17; i++) wr(6'h16, 32'(i));
    wr(6'h12, 32'h5A);
    wr(6'h12, 32'hA5);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("rst2_irq", {63'h0, irq_o}, 64'h0);
    rd_chk("rst2_ch1", 6'h13, 32'h0008_0100);
    rd_chk("rst2_ch3", 6'h17, 32'h0008_0100);
    rd_chk("rst2_ch0_thr", 6'h11, 32'h0008_0100);
    rd_chk("rst2_ch1_data", 6'h12, 32'h0001_0000);
    rd_chk("rst2_epoch", 6'h03, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
